arm_soc_lite_top: RTL and testbench

Compact SoC top for the 50 MHz FPGA board. A UART command interpreter drives a 16-bit bidirectional GPIO expansion port (EXP). The SWD debug pins are present for pin compatibility only and are inert. `SimPresent` shortens the UART bit time so simulation runs quickly.

---
 rtl/arm_soc_lite_top.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_arm_soc_lite_top.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_soc_lite_top.sv
// rtl/arm_soc_lite_top.sv - UART command interpreter driving a 16-bit GPIO expansion port
module arm_soc_lite_top #(
    parameter int SimPresent = 0
) (
    input  logic        clk50M,
    input  logic        reset_n,
    inout  wire         SWDIO,
    input  logic        SWCLK,
    output logic        TXD,
    input  logic        RXD,
    inout  wire  [15:0] EXP
);

    localparam int BIT_CLKS = (SimPresent != 0) ? 8 : 434;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam logic [8:0] BIT_LAST = 9'(BIT_CLKS - 1);
    localparam logic [8:0] HALF_LAST = 9'(HALF_CLKS - 1);

    localparam logic [7:0] CMD_OUT = 8'h4F;
    localparam logic [7:0] CMD_OE = 8'h45;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] REPLY_OK = 8'h2E;

    // debug pins kept only for board compatibility
    logic unused_swclk;
    assign unused_swclk = SWCLK;
    assign SWDIO = 1'bz;

    // GPIO registers and pin drivers
    logic [15:0] out_reg;
    logic [15:0] oe_reg;

    for (genvar i = 0; i < 16; i++) begin : g_exp
        assign EXP[i] = oe_reg[i] ? out_reg[i] : 1'bz;
    end

    // 2-flop synchronizers for the asynchronous RXD line and EXP pins
    logic        rxd_meta, rxd_sync;
    logic [15:0] exp_meta, exp_sync;

    always_ff @(posedge clk50M) begin
        if (reset_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            exp_meta <= '0;
            exp_sync <= '0;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            exp_meta <= EXP;
            exp_sync <= exp_meta;
        end
    end

    // ---------------- UART receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;
    rx_state_t   rx_state, rx_state_nxt;
    logic [8:0]  rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_valid;
    logic        rx_bit_end, rx_half_end;

    assign rx_bit_end  = (rx_cnt == BIT_LAST);
    assign rx_half_end = (rx_cnt == HALF_LAST);

    // receiver state register
    always_ff @(posedge clk50M) begin
        if (reset_n) rx_state <= RX_IDLE;
        else         rx_state <= rx_state_nxt;
    end

    // receiver next state; rx_valid fires on the stop-bit sample of a good frame
    always_comb begin
        rx_state_nxt = rx_state;
        rx_valid     = 1'b0;
        case (rx_state)
            RX_IDLE:   if (!rxd_sync) rx_state_nxt = RX_START;
            RX_START:  if (rx_half_end) rx_state_nxt = rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_bit_end && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP: begin
                if (rx_bit_end) begin
                    if (rxd_sync) begin
                        rx_valid     = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_WAITHI;
                    end
                end
            end
            RX_WAITHI: if (rxd_sync) rx_state_nxt = RX_IDLE;
            default:   rx_state_nxt = RX_IDLE;
        endcase
    end

    // receiver bit timer and LSB-first shift register
    always_ff @(posedge clk50M) begin
        if (reset_n) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state != rx_state_nxt || (rx_state == RX_DATA && rx_bit_end) ||
                rx_state == RX_IDLE || rx_state == RX_WAITHI)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 9'd1;
            if (rx_state == RX_START)
                rx_bit <= '0;
            if (rx_state == RX_DATA && rx_bit_end) begin
                rx_shift <= {rxd_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    // ---------------- command interpreter ----------------
    typedef enum logic [2:0] {CMD_IDLE, CMD_OUT_HI, CMD_OUT_LO, CMD_OE_HI, CMD_OE_LO} cmd_state_t;
    cmd_state_t  cmd_state, cmd_state_nxt;
    logic [7:0]  arg_hi;
    logic        push_req;
    logic [7:0]  push_data;
    logic        rd_lo_pend;
    logic [7:0]  rd_lo;

    // command state register
    always_ff @(posedge clk50M) begin
        if (reset_n) cmd_state <= CMD_IDLE;
        else         cmd_state <= cmd_state_nxt;
    end

    // command sequencing: each received byte advances one argument position
    always_comb begin
        cmd_state_nxt = cmd_state;
        if (rx_valid) begin
            case (cmd_state)
                CMD_IDLE: begin
                    if (rx_shift == CMD_OUT)     cmd_state_nxt = CMD_OUT_HI;
                    else if (rx_shift == CMD_OE) cmd_state_nxt = CMD_OE_HI;
                end
                CMD_OUT_HI: cmd_state_nxt = CMD_OUT_LO;
                CMD_OE_HI:  cmd_state_nxt = CMD_OE_LO;
                default:    cmd_state_nxt = CMD_IDLE;
            endcase
        end
    end

    // register writes and reply generation; a read reply queues its low byte for the next cycle
    always_ff @(posedge clk50M) begin
        if (reset_n) begin
            out_reg    <= '0;
            oe_reg     <= '0;
            arg_hi     <= '0;
            push_req   <= 1'b0;
            push_data  <= '0;
            rd_lo_pend <= 1'b0;
            rd_lo      <= '0;
        end else begin
            push_req <= 1'b0;
            if (rd_lo_pend) begin
                push_req   <= 1'b1;
                push_data  <= rd_lo;
                rd_lo_pend <= 1'b0;
            end
            if (rx_valid) begin
                case (cmd_state)
                    CMD_IDLE: begin
                        if (rx_shift == CMD_RD) begin
                            push_req   <= 1'b1;
                            push_data  <= exp_sync[15:8];
                            rd_lo      <= exp_sync[7:0];
                            rd_lo_pend <= 1'b1;
                        end else if (rx_shift != CMD_OUT && rx_shift != CMD_OE) begin
                            push_req  <= 1'b1;
                            push_data <= rx_shift;
                        end
                    end
                    CMD_OUT_HI, CMD_OE_HI: arg_hi <= rx_shift;
                    CMD_OUT_LO: begin
                        out_reg   <= {arg_hi, rx_shift};
                        push_req  <= 1'b1;
                        push_data <= REPLY_OK;
                    end
                    CMD_OE_LO: begin
                        oe_reg    <= {arg_hi, rx_shift};
                        push_req  <= 1'b1;
                        push_data <= REPLY_OK;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- TX FIFO (4 x 8) ----------------
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_cnt;
    logic       fifo_push, fifo_pop;

    assign fifo_push = push_req && (fifo_cnt != 3'd4);

    // FIFO storage; entries need no reset since occupancy is tracked separately
    always_ff @(posedge clk50M) begin
        if (fifo_push) fifo_mem[wr_ptr] <= push_data;
    end

    // FIFO pointers and occupancy; a push into a full FIFO is dropped
    always_ff @(posedge clk50M) begin
        if (reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 2'd1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------- UART transmitter ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t  tx_state, tx_state_nxt;
    logic [8:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic       tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    // transmitter state register
    always_ff @(posedge clk50M) begin
        if (reset_n) tx_state <= TX_IDLE;
        else         tx_state <= tx_state_nxt;
    end

    // transmitter next state; the stop bit chains straight into the next start bit
    always_comb begin
        tx_state_nxt = tx_state;
        fifo_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (fifo_cnt != 3'd0) begin
                    fifo_pop     = 1'b1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: if (tx_bit_end) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (fifo_cnt != 3'd0) begin
                        fifo_pop     = 1'b1;
                        tx_state_nxt = TX_START;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // transmitter bit timer and shift register
    always_ff @(posedge clk50M) begin
        if (reset_n) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            if (tx_state != tx_state_nxt || (tx_state == TX_DATA && tx_bit_end) ||
                tx_state == TX_IDLE)
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + 9'd1;
            if (fifo_pop) begin
                tx_shift <= fifo_mem[rd_ptr];
                tx_bit   <= '0;
            end else if (tx_state == TX_DATA && tx_bit_end) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

    // line level decoded from transmitter state; idle and stop are high
    always_comb begin
        TXD = 1'b1;
        case (tx_state)
            TX_START: TXD = 1'b0;
            TX_DATA:  TXD = tx_shift[0];
            default:  TXD = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_arm_soc_lite_top.sv
// tb/tb_arm_soc_lite_top.sv - randomized self-checking bench for arm_soc_lite_top
module tb_arm_soc_lite_top;

    localparam int B = 8;
    localparam int HALF = B / 2;

    logic        clk50M = 1'b0;
    logic        reset_n;
    logic        SWCLK;
    logic        TXD;
    logic        RXD;
    wire         SWDIO;
    wire  [15:0] EXP;

    logic [15:0] tb_drv;
    logic [15:0] tb_drv_en;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stop_cyc = 0;
    logic mon_en;

    logic [7:0] mon_q[$];
    int         mon_t[$];
    logic [7:0] exp_q[$];

    logic [15:0] out_m;
    logic [15:0] oe_m;

    always #10 clk50M = ~clk50M;

    always @(posedge clk50M) cyc <= cyc + 1;

    for (genvar i = 0; i < 16; i++) begin : g_drv
        assign EXP[i] = tb_drv_en[i] ? tb_drv[i] : 1'bz;
    end

    arm_soc_lite_top #(.SimPresent(1)) dut (
        .clk50M (clk50M),
        .reset_n(reset_n),
        .SWDIO  (SWDIO),
        .SWCLK  (SWCLK),
        .TXD    (TXD),
        .RXD    (RXD),
        .EXP    (EXP)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk50M);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RXD = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            tick(B);
        end
        stop_cyc = cyc;
        RXD = 1'b1;
        tick(B);
    endtask

    function automatic logic [15:0] pins_model();
        return (out_m & oe_m) | (tb_drv & ~oe_m);
    endfunction

    task automatic compare_replies(input string tag);
        chk({tag, "_count"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
            chk(tag, mon_q[i], exp_q[i]);
        mon_q.delete();
        mon_t.delete();
        exp_q.delete();
    endtask

    // TXD frame decoder: samples each bit at its middle on the falling clock edge
    initial begin
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge clk50M);
            if (TXD == 1'b0) begin
                t0 = cyc;
                repeat (HALF) @(negedge clk50M);
                if (TXD == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (B) @(negedge clk50M);
                        b[i] = TXD;
                    end
                    repeat (B) @(negedge clk50M);
                    if (mon_en) begin
                        chk("tx_stop_bit", TXD, 1'b1);
                        mon_q.push_back(b);
                        mon_t.push_back(t0);
                    end
                end
            end
        end
    end

    initial begin
        int lows;
        int d;
        int j;
        int found;
        int kind;
        logic [7:0] hi, lo, ub;
        logic ok;

        reset_n = 1'b1;
        RXD = 1'b1;
        SWCLK = 1'b0;
        tb_drv = '0;
        tb_drv_en = '0;
        mon_en = 1'b1;
        out_m = '0;
        oe_m = '0;

        tick(2);
        reset_n = 1'b0;
        chk("reset_txd", TXD, 1'b1);

        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk50M);
            if (TXD == 1'b0) lows++;
        end
        tick(1);
        chk("idle_txd_low_cycles", lows, 0);
        chk("idle_frames", mon_q.size(), 0);

        // all pins are inputs after reset: the bench owns every bit
        tb_drv = 16'h1234;
        tb_drv_en = 16'hFFFF;
        tick(10);
        chk("exp_undriven_by_dut", EXP, 16'h1234);
        send_byte(8'h52);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        tick(250);
        compare_replies("read_after_reset");

        // single echo with start-bit latency relative to the stop bit
        send_byte(8'h41);
        exp_q.push_back(8'h41);
        tick(250);
        d = (mon_t.size() > 0) ? (mon_t[0] - stop_cyc) : -1;
        chk("echo_latency_in_window", (d >= HALF && d <= HALF + 6), 1'b1);
        compare_replies("echo_41");

        // upper byte becomes output, lower byte stays bench-driven
        tb_drv = 16'h005A;
        tb_drv_en = 16'h00FF;
        send_byte(8'h45); send_byte(8'hFF); send_byte(8'h00);
        oe_m = 16'hFF00;
        exp_q.push_back(8'h2E);
        send_byte(8'h4F); send_byte(8'hA5); send_byte(8'h3C);
        out_m = 16'hA53C;
        exp_q.push_back(8'h2E);
        tick(250);
        compare_replies("write_oe_out");
        chk("exp_hi_driven", EXP[15:8], 8'hA5);
        chk("exp_lo_bench", EXP[7:0], 8'h5A);

        // read reply is two back-to-back frames
        send_byte(8'h52);
        exp_q.push_back(pins_model() >> 8);
        exp_q.push_back(pins_model() & 16'hFF);
        tick(250);
        d = (mon_t.size() > 1) ? (mon_t[1] - mon_t[0]) : -1;
        chk("read_back_to_back", d, 10 * B);
        compare_replies("read_a55a");

        // break condition yields nothing, then reception recovers
        RXD = 1'b0;
        tick(500);
        RXD = 1'b1;
        tick(300);
        chk("break_no_tx", mon_q.size(), 0);
        send_byte(8'h55);
        exp_q.push_back(8'h55);
        tick(250);
        compare_replies("after_break");

        // argument bytes equal to command codes are taken raw
        send_byte(8'h4F); send_byte(8'h52); send_byte(8'h45);
        out_m = 16'h5245;
        exp_q.push_back(8'h2E);
        tick(250);
        compare_replies("args_are_codes");
        chk("exp_hi_codes", EXP[15:8], 8'h52);

        // randomized command mix
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 2);
            case (kind)
                0: begin
                    hi = 8'($urandom);
                    lo = 8'($urandom);
                    send_byte(8'h4F); send_byte(hi); send_byte(lo);
                    out_m = {hi, lo};
                    exp_q.push_back(8'h2E);
                end
                1: begin
                    tb_drv[7:0] = 8'($urandom);
                    tick(4);
                    send_byte(8'h52);
                    exp_q.push_back(pins_model() >> 8);
                    exp_q.push_back(pins_model() & 16'hFF);
                end
                default: begin
                    ub = 8'($urandom);
                    while (ub == 8'h4F || ub == 8'h45 || ub == 8'h52) ub = 8'($urandom);
                    send_byte(ub);
                    exp_q.push_back(ub);
                end
            endcase
            tick(250);
            compare_replies("rand");
            chk("rand_exp_hi", EXP[15:8], out_m[15:8]);
        end

        // reply overflow: six reads then six unknown bytes, all back-to-back
        tb_drv[7:0] = 8'h5A;
        tick(4);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h52);
            exp_q.push_back(pins_model() >> 8);
            exp_q.push_back(pins_model() & 16'hFF);
        end
        for (int i = 0; i < 6; i++) begin
            ub = 8'h60 + 8'(i);
            send_byte(ub);
            exp_q.push_back(ub);
        end
        tick(900);
        for (int i = 0; i < 5; i++)
            chk("ovf_head", (i < mon_q.size()) ? mon_q[i] : 8'hXX, exp_q[i]);
        j = 0;
        ok = 1'b1;
        for (int i = 0; i < mon_q.size(); i++) begin
            while (j < exp_q.size() && exp_q[j] != mon_q[i]) j++;
            if (j >= exp_q.size()) ok = 1'b0;
            else j++;
        end
        chk("ovf_in_order_subset", ok, 1'b1);
        chk("ovf_some_dropped", (mon_q.size() < exp_q.size()), 1'b1);
        chk("ovf_min_delivered", (mon_q.size() >= 6), 1'b1);
        mon_q.delete();
        mon_t.delete();
        exp_q.delete();

        // reset during a transmission with replies still queued
        send_byte(8'h52);
        send_byte(8'h52);
        tick(20);
        mon_en = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk50M);
            if (TXD == 1'b0) found = 1;
        end
        chk("midtx_found_low", found, 1);
        reset_n = 1'b1;
        tick(1);
        chk("midtx_reset_txd", TXD, 1'b1);
        reset_n = 1'b0;
        tb_drv_en = 16'hFFFF;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk50M);
            if (TXD == 1'b0) lows++;
        end
        chk("midtx_fifo_flushed", lows, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
